// File: rtl/seq_booth_mult_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10
  } booth_op_e;

  // Counter must reach WIDTH without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

  function automatic booth_op_e booth_decode(input logic q0, input logic qm1);
    booth_op_e op;
    case ({q0, qm1})
      2'b01:   op = OP_ADD;
      2'b10:   op = OP_SUB;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/seq_booth_mult_if.sv
// Start/busy/done handshake bundle between a requester and the multiplier.
interface seq_booth_mult_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_booth_mult_booth_step.sv
// One combinational radix-2 Booth iteration: add/sub of M, then arithmetic shift.
module booth_step
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+1:0] acc_i,
  input  logic [WIDTH:0]   q_i,
  input  logic             qm1_i,
  input  logic [WIDTH:0]   m_i,
  output logic [WIDTH+1:0] acc_o,
  output logic [WIDTH:0]   q_o,
  output logic             qm1_o
);

  logic [WIDTH+1:0] m_ext_s;
  logic [WIDTH+1:0] sum_s;
  booth_op_e        op_s;

  assign m_ext_s = {m_i[WIDTH], m_i};
  assign op_s    = booth_decode(q_i[0], qm1_i);

  // Guard bit in acc keeps acc - M exact for the most negative M.
  always_comb begin
    sum_s = acc_i;
    case (op_s)
      OP_ADD:  sum_s = acc_i + m_ext_s;
      OP_SUB:  sum_s = acc_i - m_ext_s;
      default: sum_s = acc_i;
    endcase
    acc_o = {sum_s[WIDTH+1], sum_s[WIDTH+1:1]};
    q_o   = {sum_s[0], q_i[WIDTH:1]};
    qm1_o = q_i[0];
  end

endmodule

// File: rtl/seq_booth_mult.sv
// Sequential Booth multiplier: WIDTH+1 iterations per product, signed or unsigned operands.
module seq_booth_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  seq_booth_mult_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     m_q, m_d;
  logic [WIDTH:0]     q_q, q_d;
  logic [WIDTH+1:0]   acc_q, acc_d;
  logic               qm1_q, qm1_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH+1:0]   acc_n_s;
  logic [WIDTH:0]     q_n_s;
  logic               qm1_n_s;
  logic               last_s;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc_i (acc_q),
    .q_i   (q_q),
    .qm1_i (qm1_q),
    .m_i   (m_q),
    .acc_o (acc_n_s),
    .q_o   (q_n_s),
    .qm1_o (qm1_n_s)
  );

  assign last_s = (cnt_q == CW'(WIDTH));

  // Next-state logic; operands are extended by one bit so both modes share the signed datapath.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_d       = m_q;
    q_d       = q_q;
    acc_d     = acc_q;
    qm1_d     = qm1_q;
    product_d = product_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          m_d     = {bus.is_signed & bus.a[WIDTH-1], bus.a};
          q_d     = {bus.is_signed & bus.b[WIDTH-1], bus.b};
          acc_d   = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = acc_n_s;
        q_d   = q_n_s;
        qm1_d = qm1_n_s;
        if (last_s) begin
          product_d = {acc_n_s[WIDTH-2:0], q_n_s};
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      m_q       <= '0;
      q_q       <= '0;
      acc_q     <= '0;
      qm1_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_q       <= m_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      qm1_q     <= qm1_d;
      product_q <= product_d;
    end
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.product = product_q;

endmodule

// File: tb/tb_seq_booth_mult.sv
// Self-checking bench for seq_booth_mult at WIDTH 4, 8 and 16.
module tb_seq_booth_mult;

  logic clk;
  logic rst4, rst8, rst16;
  int   checks;
  int   errors;

  seq_booth_mult_if #(.WIDTH(4))  if4  ();
  seq_booth_mult_if #(.WIDTH(8))  if8  ();
  seq_booth_mult_if #(.WIDTH(16)) if16 ();

  seq_booth_mult #(.WIDTH(4))  u4  (.clock(clk), .reset(rst4),  .bus(if4));
  seq_booth_mult #(.WIDTH(8))  u8  (.clock(clk), .reset(rst8),  .bus(if8));
  seq_booth_mult #(.WIDTH(16)) u16 (.clock(clk), .reset(rst16), .bus(if16));

  always #5 clk = ~clk;

  typedef struct {
    int          w;
    logic        sg;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Exact product of the operands interpreted in the chosen mode, truncated to 2*w bits.
  function automatic logic [31:0] ref_mult(input int w, input logic sg,
                                           input logic [15:0] av, input logic [15:0] bv);
    longint x, y, p, m;
    m = (longint'(1) << w) - 1;
    x = longint'(av) & m;
    y = longint'(bv) & m;
    if (sg && av[w-1]) x = x - (longint'(1) << w);
    if (sg && bv[w-1]) y = y - (longint'(1) << w);
    p = x * y;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic drive(input int w, input logic st, input logic sg,
                       input logic [15:0] av, input logic [15:0] bv);
    case (w)
      4:  begin if4.start  = st; if4.is_signed  = sg; if4.a  = av[3:0]; if4.b  = bv[3:0]; end
      8:  begin if8.start  = st; if8.is_signed  = sg; if8.a  = av[7:0]; if8.b  = bv[7:0]; end
      default: begin if16.start = st; if16.is_signed = sg; if16.a = av; if16.b = bv; end
    endcase
  endtask

  function automatic logic get_busy(input int w);
    case (w)
      4:       return if4.busy;
      8:       return if8.busy;
      default: return if16.busy;
    endcase
  endfunction

  function automatic logic get_done(input int w);
    case (w)
      4:       return if4.done;
      8:       return if8.done;
      default: return if16.done;
    endcase
  endfunction

  function automatic logic [31:0] get_prod(input int w);
    case (w)
      4:       return {24'd0, if4.product};
      8:       return {16'd0, if8.product};
      default: return if16.product;
    endcase
  endfunction

  // Called at a negedge; returns at a negedge one cycle after the done pulse.
  task automatic do_op(input int w, input logic sg, input logic [15:0] av,
                       input logic [15:0] bv, input logic [31:0] exp, input string tag);
    logic [31:0] prev;
    int          busy_n, done_at;
    logic        stable;
    prev    = get_prod(w);
    busy_n  = 0;
    done_at = 0;
    stable  = 1'b1;
    drive(w, 1'b1, sg, av, bv);
    for (int s = 1; s <= w + 8 && done_at == 0; s++) begin
      @(negedge clk);
      if (s == 1) drive(w, 1'b0, ~sg, 16'($urandom), 16'($urandom));
      if (get_done(w)) begin
        done_at = s;
      end else begin
        if (get_busy(w)) busy_n++;
        if (get_prod(w) !== prev) stable = 1'b0;
      end
    end
    check({tag, "_done_cycle"}, 64'(done_at), 64'(w + 2));
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(w + 1));
    check({tag, "_stable_mid_run"}, 64'(stable), 64'd1);
    check({tag, "_product"}, 64'(get_prod(w)), 64'(exp));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'(get_done(w)), 64'd0);
    check({tag, "_product_hold"}, 64'(get_prod(w)), 64'(exp));
  endtask

  vec_t        vecs[11];
  logic [31:0] p1, p2, d1_prod, d2_prod;
  int          dn, d1_at, d2_at, bsy;
  logic [15:0] ra, rb;

  initial begin
    clk    = 1'b0;
    checks = 0;
    errors = 0;
    rst4 = 1'b1; rst8 = 1'b1; rst16 = 1'b1;
    drive(4, 1'b0, 1'b0, 16'd0, 16'd0);
    drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
    drive(16, 1'b0, 1'b0, 16'd0, 16'd0);

    vecs[0]  = '{4,  1'b1, 16'h000B, 16'h000D, 32'h0000_000F};
    vecs[1]  = '{4,  1'b0, 16'h000B, 16'h000D, 32'h0000_008F};
    vecs[2]  = '{4,  1'b0, 16'h000F, 16'h000F, 32'h0000_00E1};
    vecs[3]  = '{4,  1'b1, 16'h0008, 16'h0008, 32'h0000_0040};
    vecs[4]  = '{4,  1'b1, 16'h0007, 16'h0008, 32'h0000_00C8};
    vecs[5]  = '{4,  1'b1, 16'h000F, 16'h0001, 32'h0000_00FF};
    vecs[6]  = '{8,  1'b1, 16'h0080, 16'h0080, 32'h0000_4000};
    vecs[7]  = '{8,  1'b0, 16'h00FF, 16'h00FF, 32'h0000_FE01};
    vecs[8]  = '{8,  1'b1, 16'h007F, 16'h0080, 32'h0000_C080};
    vecs[9]  = '{16, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vecs[10] = '{16, 1'b1, 16'h8000, 16'h8000, 32'h4000_0000};

    repeat (3) @(negedge clk);
    check("rst_busy4", 64'(if4.busy), 64'd0);
    check("rst_done8", 64'(if8.done), 64'd0);
    check("rst_busy16", 64'(if16.busy), 64'd0);
    check("rst_prod4", 64'(get_prod(4)), 64'd0);
    check("rst_prod8", 64'(get_prod(8)), 64'd0);
    check("rst_prod16", 64'(get_prod(16)), 64'd0);
    rst4 = 1'b0; rst8 = 1'b0; rst16 = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      do_op(vecs[i].w, vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Starts pulsed during RUN must be ignored.
    p1 = ref_mult(8, 1'b1, 16'h009C, 16'h0027);
    dn = 0; d1_at = 0; d1_prod = '0;
    drive(8, 1'b1, 1'b1, 16'h009C, 16'h0027);
    for (int s = 1; s <= 14; s++) begin
      @(negedge clk);
      if (get_done(8)) begin
        dn++;
        if (d1_at == 0) begin d1_at = s; d1_prod = get_prod(8); end
      end
      if (s == 1 || s == 4 || s == 7) drive(8, 1'b0, 1'b0, 16'h0055, 16'h00AA);
      if (s == 3 || s == 6) drive(8, 1'b1, 1'b0, 16'h0011, 16'h0022);
    end
    check("ign_done_count", 64'(dn), 64'd1);
    check("ign_done_cycle", 64'(d1_at), 64'd10);
    check("ign_product", 64'(d1_prod), 64'(p1));

    // Start held through DONE restarts immediately with new operands and mode.
    p1 = ref_mult(8, 1'b1, 16'h007F, 16'h0081);
    p2 = ref_mult(8, 1'b0, 16'h00D6, 16'h005B);
    dn = 0; d1_at = 0; d2_at = 0; bsy = 0; d1_prod = '0; d2_prod = '0;
    drive(8, 1'b1, 1'b1, 16'h007F, 16'h0081);
    for (int s = 1; s <= 22; s++) begin
      @(negedge clk);
      if (get_done(8)) begin
        dn++;
        if (d1_at == 0) begin d1_at = s; d1_prod = get_prod(8); end
        else begin d2_at = s; d2_prod = get_prod(8); end
      end
      if (s >= 11 && s <= 19 && get_busy(8)) bsy++;
      if (s == 1) drive(8, 1'b0, 1'b0, 16'h0000, 16'h0000);
      if (s == 9) drive(8, 1'b1, 1'b0, 16'h00D6, 16'h005B);
      if (s == 11) drive(8, 1'b0, 1'b1, 16'h0033, 16'h0044);
    end
    check("b2b_done_count", 64'(dn), 64'd2);
    check("b2b_first_cycle", 64'(d1_at), 64'd10);
    check("b2b_first_prod", 64'(d1_prod), 64'(p1));
    check("b2b_second_cycle", 64'(d2_at), 64'd20);
    check("b2b_second_prod", 64'(d2_prod), 64'(p2));
    check("b2b_busy_cycles", 64'(bsy), 64'd9);

    // Reset four cycles into RUN aborts without a done pulse.
    dn = 0;
    drive(8, 1'b1, 1'b1, 16'h0035, 16'h00C3);
    for (int s = 1; s <= 14; s++) begin
      @(negedge clk);
      if (s >= 5 && get_done(8)) dn++;
      if (s == 1) drive(8, 1'b0, 1'b0, 16'h0000, 16'h0000);
      if (s == 4) rst8 = 1'b1;
      if (s == 5) begin
        check("mid_rst_busy", 64'(get_busy(8)), 64'd0);
        check("mid_rst_done", 64'(get_done(8)), 64'd0);
        check("mid_rst_prod", 64'(get_prod(8)), 64'd0);
        rst8 = 1'b0;
      end
    end
    check("mid_rst_no_done", 64'(dn), 64'd0);
    do_op(8, 1'b1, 16'h0035, 16'h00C3, ref_mult(8, 1'b1, 16'h0035, 16'h00C3), "post_rst");

    // Reset and start on the same edge: reset wins.
    rst8 = 1'b1;
    drive(8, 1'b1, 1'b0, 16'h0012, 16'h0034);
    @(negedge clk);
    check("rst_vs_start_busy", 64'(get_busy(8)), 64'd0);
    check("rst_vs_start_prod", 64'(get_prod(8)), 64'd0);
    rst8 = 1'b0;
    drive(8, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    check("rst_vs_start_idle", 64'(get_busy(8)), 64'd0);

    // Random operands in both modes at WIDTH 8 and 16 against the arithmetic model.
    for (int wi = 0; wi < 2; wi++) begin
      for (int m = 0; m < 2; m++) begin
        for (int n = 0; n < 1000; n++) begin
          int w;
          w  = (wi == 0) ? 8 : 16;
          ra = 16'($urandom);
          rb = 16'($urandom);
          if (n == 0) begin ra = 16'hFFFF; rb = 16'h0000; end
          do_op(w, m[0], ra, rb, ref_mult(w, m[0], ra, rb),
                $sformatf("rnd_w%0d_s%0d_%0d", w, m, n));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_booth_mult.md
# seq_booth_mult

Parametrised sequential multiplier: radix-2 Booth recoding, one iteration per clock, runtime-selectable signed or unsigned operands. It succeeds the fixed 4-bit signed shift-add multiplier. It sits in the datapath as a shared arithmetic unit behind a start/busy/done handshake. It is small-area and multi-cycle, trading latency for a single adder.

## Interface
Parameters:
- WIDTH, default 8: operand width in bits; legal range is WIDTH >= 2. Product width is 2*WIDTH.

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clock
- start  in  1  request; sampled only in IDLE or DONE
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; captured with operands
- a  in  WIDTH  multiplicand; captured on accepted start
- b  in  WIDTH  multiplier; captured on accepted start
- busy  out  1  high while state is RUN
- done  out  1  one-cycle pulse; product valid from this cycle on
- product  out  2*WIDTH  result register; holds until the next completion or reset

## Operation
- States:
  - IDLE: after reset. On start, load operands, counter = 0, go to RUN.
  - RUN: one Booth step per cycle, for WIDTH+1 steps.
  - DONE: lasts one cycle, with done = 1. On start, reload operands and go to RUN; otherwise go to IDLE.
- Operand extension to WIDTH+1 bits:
  - is_signed = 1: sign-extend a and b.
  - is_signed = 0: zero-extend a and b.
  - After extension, both modes run the same signed Booth datapath.
- Working registers:
  - M: WIDTH+1 bits, the extended a.
  - acc: WIDTH+2 bits, initialised to 0.
  - Q: WIDTH+1 bits, the extended b.
  - q_m1: 1 bit, initialised to 0.
- Booth step, selected by {Q[0], q_m1}:
  - 01: acc = acc + sext(M).
  - 10: acc = acc - sext(M).
  - 00 or 11: acc unchanged.
  - Then arithmetic right shift of {acc, Q, q_m1} by 1; acc MSB replicates.
- Result:
  - After WIDTH+1 steps, product = low 2*WIDTH bits of {acc, Q}.
  - This value is the exact product in both modes; no overflow is possible.
- start while busy: ignored. Operands and is_signed are not resampled.
- a, b and is_signed may change freely after the accepting edge.

## Timing
- Reset values: state IDLE, busy 0, done 0, product 0, counter 0, all working registers 0.
- Latency:
  - start is sampled high at edge k.
  - busy is high during cycles k+1 .. k+WIDTH+1 (WIDTH+1 cycles).
  - At edge k+WIDTH+1, product is updated and state becomes DONE.
  - done is high in the cycle after edge k+WIDTH+1; for WIDTH = 8, done is high 9 cycles after the accepting edge.
- Back-to-back: start high in the DONE cycle is accepted at that edge. busy rises the next cycle and done falls. Sustained throughput is one result per WIDTH+2 cycles.
- product changes only at the completing edge and at reset. It is never visible mid-computation.
- Reset mid-RUN: at the next edge, abort to IDLE, zero product, and emit no done pulse.
- reset and start high on the same edge: reset wins.
- Counter: ceil(log2(WIDTH+2)) bits. It must not wrap before the terminal count WIDTH.

## Structure
- Package seq_mult_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the Booth opcode constants (NOP, ADD, SUB);
  - a function clog2-based counter width helper.
- Sub-module booth_step is purely combinational:
  - inputs: acc, Q, q_m1, M;
  - outputs: next acc, Q, q_m1.
  - It holds the add/sub and the shift.
- The top level holds the FSM, counter, registers and the product/done outputs.

## Test plan
- WIDTH=4, is_signed=1, a=4'b1011 (-5), b=4'b1101 (-3) -> done after 5 cycles; product=8'h0F (15).
- WIDTH=4:
  - is_signed=0, a=11, b=13 -> product=8'h8F (143).
  - is_signed=0, a=15, b=15 -> product=8'hE1.
  - is_signed=1, a=-8, b=-8 -> product=8'h40.
  - is_signed=1, a=7, b=-8 -> product=8'hC8.
- WIDTH=8:
  - is_signed=1, start pulsed again at cycles 3 and 6 of RUN -> ignored.
  - A single done arrives 9 cycles after the first accept, with product equal to the first operands' result.
  - Back-to-back: start held high through DONE -> a second result completes after another 9 cycles of busy.
- WIDTH=8, reset asserted 4 cycles into RUN -> next cycle state IDLE, busy=0, product=0, no done pulse. A subsequent start computes correctly.
- WIDTH=8 and WIDTH=16, 1000 random operands in each mode -> product matches the reference model (signed or unsigned a*b) at every done pulse. Also check product is stable between done pulses.
